// File: rtl/cpu_pkg.sv
// Shared definitions for the memory-port arbiter: FSM states and read-latency limits.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_t;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 8;
  localparam int CNT_W       = $clog2(LATENCY_MAX);

  function automatic int clamp_latency(input int lat);
    if (lat < LATENCY_MIN) return LATENCY_MIN;
    if (lat > LATENCY_MAX) return LATENCY_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/lat_counter.sv
// Access-latency down-counter: load, decrement and a flag for the cycle in which the
// decrement reaches zero.
module lat_counter
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Asserted in the last busy cycle so completion lands on the edge that empties the count.
  assign zero = dec && (cnt == CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data memory.
// Define ARB_ROUND_ROBIN_EN to replace fixed data priority with last-winner alternation.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam int               LAT      = clamp_latency(LATENCY);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LAT - 1);

  arb_state_t state;
  logic       grant_if;
  logic       grant_dm;
  logic       grant;
  logic       dm_wr;
  logic       cnt_zero;
`ifdef ARB_ROUND_ROBIN_EN
  logic       last_dm;
`endif

  always_comb begin
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (rst_n && (state == IDLE)) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (dm_req && (!if_req || !last_dm)) grant_dm = 1'b1;
      else if (if_req)                     grant_if = 1'b1;
`else
      if (dm_req)      grant_dm = 1'b1;
      else if (if_req) grant_if = 1'b1;
`endif
    end
  end

  assign grant     = grant_if || grant_dm;
  assign if_gnt    = grant_if;
  assign dm_gnt    = grant_dm;
  assign mem_en    = grant;
  assign mem_we    = grant_dm && dm_we;
  assign mem_addr  = grant_dm ? dm_addr : (grant_if ? if_addr : '0);
  assign mem_wdata = grant_dm ? dm_wdata : '0;
  assign stall_if  = if_req && !if_valid;
  assign stall_mem = dm_req && !dm_valid;

  lat_counter u_lat_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (grant && (LAT != 1)),
    .load_val (LOAD_VAL),
    .dec      (state != IDLE),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      dm_wr    <= 1'b0;
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_dm  <= 1'b0;
`endif
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            dm_wr <= grant_dm && dm_we;
`ifdef ARB_ROUND_ROBIN_EN
            last_dm <= grant_dm;
`endif
            // Single-cycle memory completes on the grant edge itself, keeping one access per cycle.
            if (LAT == 1) begin
              if (grant_if) begin
                if_valid <= 1'b1;
                if_rdata <= mem_rdata;
              end else begin
                dm_valid <= 1'b1;
                if (!dm_we) dm_rdata <= mem_rdata;
              end
            end else begin
              state <= grant_dm ? BUSY_DM : BUSY_IF;
            end
          end
        end
        BUSY_IF: begin
          if (cnt_zero) begin
            if_valid <= 1'b1;
            if_rdata <= mem_rdata;
            state    <= IDLE;
          end
        end
        BUSY_DM: begin
          if (cnt_zero) begin
            dm_valid <= 1'b1;
            if (!dm_wr) dm_rdata <= mem_rdata;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
